// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage.
package if_stage_pkg;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } if_state_t;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID register and a one-entry
// pending buffer that parks a word accepted while decode is stalled.
import if_stage_pkg::*;

module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  input  logic               halt_req,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [31:0]        pc,
  output logic [31:0]        PC_plus_4,
  output logic [INSTR_W-1:0] instruction,
  output logic               if_valid
);

  if_state_t          state;
  logic [INSTR_W-1:0] pend_instr;
  logic [31:0]        pend_pc4;
  logic [31:0]        pc_inc;
  logic               accept;

  // The fetch address is the architectural PC itself.
  assign imem_addr = pc;
  assign pc_inc    = pc + 32'd4;                 // wraps modulo 2^32
  assign accept    = imem_req & imem_ready;

  // Fetch FSM with priority branch > halt > stall > fetch; HALT only exits on reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      PC_plus_4   <= 32'h0;
      instruction <= NOP_INSTR;
      if_valid    <= 1'b0;
      pend_instr  <= NOP_INSTR;
      pend_pc4    <= 32'h0;
      imem_req    <= 1'b0;
    end else if (state != HALT) begin
      if (branch_taken) begin
        // Redirect wins over stall; any word arriving now or parked is dropped.
        pc         <= word_align(branch_target);
        if_valid   <= 1'b0;
        pend_instr <= NOP_INSTR;
        pend_pc4   <= 32'h0;
        state      <= FETCH;
        imem_req   <= 1'b1;
      end else if (halt_req) begin
        state    <= HALT;
        if_valid <= 1'b0;
        imem_req <= 1'b0;
      end else if (state == HOLD) begin
        if (!stall) begin
          instruction <= pend_instr;
          PC_plus_4   <= pend_pc4;
          if_valid    <= 1'b1;
          pc          <= pc_inc;
          state       <= FETCH;
          imem_req    <= 1'b1;
        end
      end else begin
        // FETCH: request stays up unless a word gets parked.
        imem_req <= !(accept && stall);
        if (accept && stall) begin
          pend_instr <= imem_data;
          pend_pc4   <= pc_inc;
          state      <= HOLD;
        end else if (accept) begin
          instruction <= imem_data;
          PC_plus_4   <= pc_inc;
          if_valid    <= 1'b1;
          pc          <= pc_inc;
        end else if (!stall) begin
          if_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: one task per scenario, inline checks.
module tb_if_stage;

  logic        clk, rst_b, stall, branch_taken, halt_req, imem_ready;
  logic [31:0] branch_target, imem_data;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, pc, PC_plus_4, instruction;

  int checks = 0;
  int passed = 0;

  localparam logic [31:0] WA = 32'hA0A0_0001;
  localparam logic [31:0] WB = 32'hB0B0_0002;
  localparam logic [31:0] WC = 32'hC0C0_0003;
  localparam logic [31:0] WD = 32'hD0D0_0004;
  localparam logic [31:0] WE = 32'hE0E0_0005;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_b(rst_b), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt_req(halt_req), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_data(imem_data),
    .pc(pc), .PC_plus_4(PC_plus_4), .instruction(instruction), .if_valid(if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, land 1 time unit after it.
  task automatic step();
    @(posedge clk); #1;
  endtask

  // Reset, release, and take the one edge where imem_req rises.
  task automatic do_reset();
    rst_b = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    halt_req = 1'b0; imem_ready = 1'b0; imem_data = 32'h0;
    step(); step();
    rst_b = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_b = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    halt_req = 1'b0; imem_ready = 1'b1; imem_data = WA;
    step(); step();
    checks++; if (pc !== 32'h0) $display("FAIL rst_pc got %h exp %h", pc, 32'h0); else passed++;
    checks++; if (instruction !== 32'h0) $display("FAIL rst_instr got %h exp %h", instruction, 32'h0); else passed++;
    checks++; if (PC_plus_4 !== 32'h0) $display("FAIL rst_pc4 got %h exp %h", PC_plus_4, 32'h0); else passed++;
    checks++; if (if_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", if_valid); else passed++;
    checks++; if (imem_req !== 1'b0) $display("FAIL rst_req got %b exp 0", imem_req); else passed++;
    rst_b = 1'b1;
    step();
    // imem_req was low at this edge, so nothing was accepted.
    checks++; if (imem_req !== 1'b1) $display("FAIL rst_req_rise got %b exp 1", imem_req); else passed++;
    checks++; if (if_valid !== 1'b0) $display("FAIL rst_first_edge_valid got %b exp 0", if_valid); else passed++;
    checks++; if (pc !== 32'h0) $display("FAIL rst_first_edge_pc got %h exp %h", pc, 32'h0); else passed++;
  endtask

  task automatic test_stream();
    do_reset();
    imem_ready = 1'b1; imem_data = WA; step();
    checks++; if (instruction !== WA || PC_plus_4 !== 32'd4 || if_valid !== 1'b1)
      $display("FAIL stream_A got %h/%h/%b exp %h/%h/1", instruction, PC_plus_4, if_valid, WA, 32'd4); else passed++;
    imem_data = WB; step();
    checks++; if (instruction !== WB || PC_plus_4 !== 32'd8 || if_valid !== 1'b1)
      $display("FAIL stream_B got %h/%h/%b exp %h/%h/1", instruction, PC_plus_4, if_valid, WB, 32'd8); else passed++;
    imem_data = WC; step();
    checks++; if (instruction !== WC || PC_plus_4 !== 32'd12 || if_valid !== 1'b1)
      $display("FAIL stream_C got %h/%h/%b exp %h/%h/1", instruction, PC_plus_4, if_valid, WC, 32'd12); else passed++;
    checks++; if (pc !== 32'd12 || imem_addr !== 32'd12) $display("FAIL stream_pc got %h/%h exp %h", pc, imem_addr, 32'd12); else passed++;
  endtask

  task automatic test_stall();
    do_reset();
    imem_ready = 1'b1; imem_data = WA; step();
    imem_data = WB; stall = 1'b1; step();
    imem_data = WC;
    for (int i = 0; i < 3; i++) begin
      checks++; if (instruction !== WA || PC_plus_4 !== 32'd4 || pc !== 32'd4 || imem_req !== 1'b0)
        $display("FAIL stall_hold%0d got %h/%h/%h/%b exp %h/%h/%h/0", i, instruction, PC_plus_4, pc, imem_req, WA, 32'd4, 32'd4); else passed++;
      if (i == 2) stall = 1'b0;
      step();
    end
    checks++; if (instruction !== WB || PC_plus_4 !== 32'd8 || pc !== 32'd8 || if_valid !== 1'b1)
      $display("FAIL stall_release got %h/%h/%h/%b exp %h/%h/%h/1", instruction, PC_plus_4, pc, if_valid, WB, 32'd8, 32'd8); else passed++;
    checks++; if (imem_req !== 1'b1) $display("FAIL stall_req_back got %b exp 1", imem_req); else passed++;
    stall = 1'b0; step();
    checks++; if (instruction !== WC || PC_plus_4 !== 32'd12) $display("FAIL stall_next got %h/%h exp %h/%h", instruction, PC_plus_4, WC, 32'd12); else passed++;
  endtask

  task automatic test_branch_hold();
    do_reset();
    imem_ready = 1'b1; imem_data = WA; step();
    imem_data = WB; stall = 1'b1; step();
    branch_taken = 1'b1; branch_target = 32'h0000_0043; step();
    checks++; if (if_valid !== 1'b0) $display("FAIL br_valid got %b exp 0", if_valid); else passed++;
    checks++; if (pc !== 32'h40 || imem_addr !== 32'h40) $display("FAIL br_pc got %h/%h exp %h", pc, imem_addr, 32'h40); else passed++;
    checks++; if (imem_req !== 1'b1 || instruction === WB) $display("FAIL br_req_instr got %b/%h exp 1/not %h", imem_req, instruction, WB); else passed++;
    branch_taken = 1'b0; stall = 1'b0; imem_data = WD; step();
    checks++; if (instruction !== WD || PC_plus_4 !== 32'h44 || pc !== 32'h44 || if_valid !== 1'b1)
      $display("FAIL br_target_fetch got %h/%h/%h/%b exp %h/%h/%h/1", instruction, PC_plus_4, pc, if_valid, WD, 32'h44, 32'h44); else passed++;
  endtask

  task automatic test_ready_low();
    do_reset();
    imem_ready = 1'b1; imem_data = WA; step();
    imem_ready = 1'b0; imem_data = WB;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (if_valid !== 1'b0 || pc !== 32'd4 || instruction !== WA)
        $display("FAIL rdy_low%0d got %b/%h/%h exp 0/%h/%h", i, if_valid, pc, instruction, 32'd4, WA); else passed++;
    end
    imem_ready = 1'b1; step();
    checks++; if (instruction !== WB || PC_plus_4 !== 32'd8 || if_valid !== 1'b1)
      $display("FAIL rdy_resume got %h/%h/%b exp %h/%h/1", instruction, PC_plus_4, if_valid, WB, 32'd8); else passed++;
  endtask

  task automatic test_halt();
    do_reset();
    imem_ready = 1'b1; imem_data = WA; step();
    halt_req = 1'b1; imem_data = WB; step();
    checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || pc !== 32'd4)
      $display("FAIL halt_enter got %b/%b/%h exp 0/0/%h", imem_req, if_valid, pc, 32'd4); else passed++;
    halt_req = 1'b0; branch_taken = 1'b1; branch_target = 32'h100; step(); step();
    checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || pc !== 32'd4)
      $display("FAIL halt_ignore_br got %b/%b/%h exp 0/0/%h", imem_req, if_valid, pc, 32'd4); else passed++;
    branch_taken = 1'b0;
    rst_b = 1'b0; #2;
    checks++; if (pc !== 32'h0 || imem_req !== 1'b0) $display("FAIL halt_rst got %h/%b exp %h/0", pc, imem_req, 32'h0); else passed++;
    step(); rst_b = 1'b1; step();
    checks++; if (imem_req !== 1'b1) $display("FAIL halt_req_rise got %b exp 1", imem_req); else passed++;
    imem_data = WE; step();
    checks++; if (instruction !== WE || pc !== 32'd4 || if_valid !== 1'b1)
      $display("FAIL halt_resume got %h/%h/%b exp %h/%h/1", instruction, pc, if_valid, WE, 32'd4); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    // Word offered alongside the redirect must be dropped.
    imem_ready = 1'b1; imem_data = WA; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE; step();
    checks++; if (pc !== 32'hFFFF_FFFC || if_valid !== 1'b0) $display("FAIL wrap_br got %h/%b exp %h/0", pc, if_valid, 32'hFFFF_FFFC); else passed++;
    branch_taken = 1'b0; imem_data = WC; step();
    checks++; if (PC_plus_4 !== 32'h0 || pc !== 32'h0 || instruction !== WC || if_valid !== 1'b1)
      $display("FAIL wrap_pc got %h/%h/%h/%b exp 0/0/%h/1", PC_plus_4, pc, instruction, if_valid, WC); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch_hold();
    test_ready_low();
    test_halt();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
